// File: rtl/johnson_ring_counter_if.sv
// Control and status bundle for johnson_ring_counter.
// The counter drives the status signals and the controller drives the rest.
interface johnson_ring_counter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IW = $clog2(2 * N);

  logic          en;
  logic          clr;
  logic          load;
  logic [N-1:0]  load_val;
  logic          mode;
  logic          dir;
  logic [N-1:0]  count;
  logic [IW-1:0] index;
  logic          tc;
  logic          illegal;

  modport master (
    output en, clr, load, load_val, mode, dir,
    input  count, index, tc, illegal
  );

  modport slave (
    input  en, clr, load, load_val, mode, dir,
    output count, index, tc, illegal
  );
endinterface

// File: rtl/johnson_ring_counter.sv
// Johnson/ring shift counter with up/down direction, clear, parallel load and
// one-cycle recovery from illegal states; decodes index, terminal count and legality.
module johnson_ring_counter #(
  parameter int unsigned N = 4
) (
  input logic                  clk,
  input logic                  arst_n,
  johnson_ring_counter_if.slave bus
);
  localparam int unsigned IW = $clog2(2 * N);

  logic [N-1:0]  count_q, count_d;
  logic [N-1:0]  seed, shifted;
  logic [N-2:0]  edges;
  logic          j_legal, r_legal, legal, tc;
  logic [IW-1:0] j_index, r_index, index, last;
  int            ones;

  assign seed = bus.mode ? {{(N - 1){1'b0}}, 1'b1} : '0;

  // Decode: a Johnson state has at most one boundary between adjacent bits.
  always_comb begin
    edges   = count_q[N-2:0] ^ count_q[N-1:1];
    j_legal = ($countones(edges) <= 1);
    ones    = $countones(count_q);
    // Ones packed at the LSB end (or all zero) count up; ones at the MSB end fill the second half.
    if (count_q[0] || (ones == 0)) begin
      j_index = IW'(ones);
    end else begin
      j_index = IW'(2 * N - ones);
    end
    r_legal = $onehot(count_q);
    r_index = '0;
    for (int i = 0; i < N; i++) begin
      if (count_q[i]) begin
        r_index = IW'(i);
      end
    end
    legal = bus.mode ? r_legal : j_legal;
    index = legal ? (bus.mode ? r_index : j_index) : '0;
    last  = bus.mode ? IW'(N - 1) : IW'(2 * N - 1);
    tc    = legal && (bus.dir ? (index == '0) : (index == last));
  end

  always_comb begin
    shifted = count_q;
    unique case ({bus.mode, bus.dir})
      2'b00: shifted = {count_q[N-2:0], ~count_q[N-1]};
      2'b01: shifted = {~count_q[0], count_q[N-1:1]};
      2'b10: shifted = {count_q[N-2:0], count_q[N-1]};
      2'b11: shifted = {count_q[0], count_q[N-1:1]};
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (bus.clr) begin
      count_d = seed;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      count_d = legal ? shifted : seed;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.index   = index;
  assign bus.tc      = tc;
  assign bus.illegal = ~legal;
endmodule

// File: tb/tb_johnson_ring_counter.sv
// Runs N=3, N=4 and N=8 counters in lockstep from shared stimulus against a
// table-driven reference model through an expected-result queue.
module tb_johnson_ring_counter;
  typedef struct packed {
    logic [7:0] count;
    logic [3:0] index;
    logic       tc;
    logic       illegal;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0;
  logic [7:0] load_val = 8'h00;

  int   n_checks = 0;
  int   n_pass = 0;
  int   nw[3] = '{3, 4, 8};
  logic [7:0] st[3];
  exp_t sb_q[$];
  exp_t obs4;
  logic [7:0] tbl[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h00};

  always #5 clk = ~clk;

  johnson_ring_counter_if #(.N(3)) if3 ();
  johnson_ring_counter_if #(.N(4)) if4 ();
  johnson_ring_counter_if #(.N(8)) if8 ();

  assign if3.en = en;  assign if3.clr = clr;  assign if3.load = load;
  assign if3.mode = mode;  assign if3.dir = dir;  assign if3.load_val = load_val[2:0];
  assign if4.en = en;  assign if4.clr = clr;  assign if4.load = load;
  assign if4.mode = mode;  assign if4.dir = dir;  assign if4.load_val = load_val[3:0];
  assign if8.en = en;  assign if8.clr = clr;  assign if8.load = load;
  assign if8.mode = mode;  assign if8.dir = dir;  assign if8.load_val = load_val;

  johnson_ring_counter #(.N(3)) dut3 (.clk(clk), .arst_n(arst_n), .bus(if3.slave));
  johnson_ring_counter #(.N(4)) dut4 (.clk(clk), .arst_n(arst_n), .bus(if4.slave));
  johnson_ring_counter #(.N(8)) dut8 (.clk(clk), .arst_n(arst_n), .bus(if8.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask_of(input int n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  // Reference decode: enumerate the mode's sequence and look the state up in it.
  function automatic exp_t model_out(input int n, input logic [7:0] c, input logic md,
                                     input logic dr);
    exp_t       e;
    logic [7:0] s;
    logic       found;
    int         idx;
    found = 1'b0;
    idx   = 0;
    if (!md) begin
      s = 8'h00;
      for (int k = 0; k < 2 * n; k++) begin
        if (!found && c == s) begin
          found = 1'b1;
          idx   = k;
        end
        s = ((s << 1) | {7'b0, ~s[n-1]}) & mask_of(n);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!found && c == (8'd1 << k)) begin
          found = 1'b1;
          idx   = k;
        end
      end
    end
    e.count   = c;
    e.illegal = ~found;
    e.index   = found ? 4'(idx) : 4'd0;
    e.tc      = found && (dr ? (idx == 0) : (idx == (md ? n - 1 : 2 * n - 1)));
    return e;
  endfunction

  function automatic logic [7:0] model_next(input int n, input logic [7:0] c);
    exp_t       e;
    logic [7:0] seed;
    logic       b;
    e    = model_out(n, c, mode, dir);
    seed = mode ? 8'd1 : 8'd0;
    if (clr) return seed;
    if (load) return load_val & mask_of(n);
    if (!en) return c;
    if (e.illegal) return seed;
    if (!dir) begin
      b = mode ? c[n-1] : ~c[n-1];
      return ((c << 1) | {7'b0, b}) & mask_of(n);
    end
    b = mode ? c[0] : ~c[0];
    return (c >> 1) | ({7'b0, b} << (n - 1));
  endfunction

  task automatic sample(input int i, output exp_t o);
    case (i)
      0: o = '{count: 8'(if3.count), index: 4'(if3.index), tc: if3.tc, illegal: if3.illegal};
      1: o = '{count: 8'(if4.count), index: 4'(if4.index), tc: if4.tc, illegal: if4.illegal};
      default:
        o = '{count: 8'(if8.count), index: 4'(if8.index), tc: if8.tc, illegal: if8.illegal};
    endcase
  endtask

  task automatic compare(input string tag, input int i, input exp_t o, input exp_t e);
    check($sformatf("%s n%0d count", tag, nw[i]), 32'(o.count), 32'(e.count));
    check($sformatf("%s n%0d index", tag, nw[i]), 32'(o.index), 32'(e.index));
    check($sformatf("%s n%0d tc", tag, nw[i]), 32'(o.tc), 32'(e.tc));
    check($sformatf("%s n%0d illegal", tag, nw[i]), 32'(o.illegal), 32'(e.illegal));
  endtask

  // One clock: predict every instance, push, then pop and compare after the edge.
  task automatic step(input string tag);
    exp_t o, e;
    for (int i = 0; i < 3; i++) begin
      st[i] = model_next(nw[i], st[i]);
      sb_q.push_back(model_out(nw[i], st[i], mode, dir));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
      sample(i, o);
      if (i == 1) obs4 = o;
      compare(tag, i, o, e);
    end
  endtask

  task automatic now_check(input string tag);
    exp_t o;
    #1;
    for (int i = 0; i < 3; i++) begin
      sample(i, o);
      compare(tag, i, o, model_out(nw[i], st[i], mode, dir));
    end
  endtask

  // Reset between edges must clear the count before the next edge arrives.
  task automatic reset_pulse(input string tag);
    exp_t o;
    #2 arst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 8'h00;
      sample(i, o);
      compare(tag, i, o, model_out(nw[i], st[i], mode, dir));
    end
    arst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) st[i] = 8'h00;
    #21;
    now_check("reset j up");
    dir = 1'b1;
    now_check("reset j down");
    mode = 1'b1;
    dir  = 1'b0;
    now_check("reset ring");
    mode   = 1'b0;
    arst_n = 1'b1;

    // Full Johnson up cycle; N=4 also against fixed constants.
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step("j up");
      check("j up n4 const count", 32'(obs4.count), 32'(tbl[k % 8]));
      check("j up n4 const tc", 32'(obs4.tc), 32'(tbl[k % 8] == 8'h08));
    end

    // Load then count down through the wrap.
    load     = 1'b1;
    load_val = 8'h07;
    step("load 0111");
    load = 1'b0;
    dir  = 1'b1;
    for (int k = 0; k < 4; k++) step("j down");
    check("j down n4 end count", 32'(obs4.count), 32'h8);

    // Ring mode from reset: illegal 0000 recovers to seed, then rotates.
    en   = 1'b0;
    mode = 1'b1;
    dir  = 1'b0;
    reset_pulse("ring reset");
    en = 1'b1;
    step("ring fix");
    check("ring fix n4 const", 32'(obs4.count), 32'h1);
    for (int k = 0; k < 4; k++) step("ring up");
    dir = 1'b1;
    for (int k = 0; k < 3; k++) step("ring down");

    // Illegal loads and one-cycle correction in both modes.
    mode     = 1'b0;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 8'h05;
    step("load illegal j");
    load = 1'b0;
    dir  = 1'b0;
    now_check("illegal j");
    en = 1'b1;
    step("fix j");
    mode     = 1'b1;
    load     = 1'b1;
    load_val = 8'h06;
    step("load illegal r");
    load = 1'b0;
    step("fix r");
    check("fix r n4 const", 32'(obs4.count), 32'h1);

    // Priority clr > load > en, then hold.
    clr      = 1'b1;
    load     = 1'b1;
    load_val = 8'hFF;
    step("prio clr");
    clr      = 1'b0;
    load_val = 8'h04;
    step("prio load");
    load = 1'b0;
    en   = 1'b0;
    for (int k = 0; k < 3; k++) step("hold");
    check("hold n4 const", 32'(obs4.count), 32'h4);

    // Async reset mid-count, resume, then reverse direction mid-sequence.
    mode     = 1'b0;
    load     = 1'b1;
    load_val = 8'h07;
    step("reload");
    load = 1'b0;
    en   = 1'b1;
    reset_pulse("mid reset");
    for (int k = 0; k < 3; k++) step("resume");
    check("resume n4 const", 32'(obs4.count), 32'h7);
    dir = 1'b1;
    step("reverse");
    check("reverse n4 const", 32'(obs4.count), 32'h3);
    step("reverse 2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/johnson_ring_counter.md
Name: johnson_ring_counter

Overview:
Parametrised shift-register counter, a successor to the plain behavioural Johnson counter. It provides Johnson and ring modes, up/down direction, enable, synchronous clear, parallel load and illegal-state self-correction. It also provides decoded state index, terminal-count and illegal-state outputs. It serves as a reusable sequencer/timing-phase generator in digitaljs teaching designs.

Parameters:
N, 4, register width in bits; legal range N >= 2.
IW (localparam), $clog2(2*N), width of index output.

Ports:
clk  in  1  rising-edge clock
arst_n  in  1  asynchronous reset, active low
en  in  1  advance one state this cycle
clr  in  1  synchronous clear to mode seed state
load  in  1  synchronous parallel load
load_val  in  N  value written on load
mode  in  1  0 = Johnson (2N states), 1 = ring (N states)
dir  in  1  0 = up (shift toward MSB), 1 = down (shift toward LSB)
count  out  N  registered counter state
index  out  IW  decoded position of count in the current mode's sequence
tc  out  1  terminal count for current mode/direction
illegal  out  1  count is not a legal state of the current mode

Behaviour:
- Reset: arst_n low forces count = 0 immediately, independent of clk. With count = 0: index = 0; tc = 1 if mode=0, dir=1; illegal = 1 if mode=1.
- Priority per rising edge: clr > load > en > hold.
- clr: count <= seed. Seed is 0 in Johnson mode, {N-1 zeros, 1} in ring mode.
- load: count <= load_val, stored unmodified even when illegal.
- en with legal count:
  - Johnson up: count <= {count[N-2:0], ~count[N-1]}
  - Johnson down: count <= {~count[0], count[N-1:1]}
  - Ring up: count <= {count[N-2:0], count[N-1]}
  - Ring down: count <= {count[0], count[N-1:1]}
- en with illegal count: count <= seed of current mode. Correction takes exactly one enabled cycle; no illegal state persists past one en cycle.
- Wrap-around is implicit in the shift. Johnson up from index 2N-1 goes to index 0; ring up from index N-1 goes to index 0. Down mirrors this.
- Johnson legal states:
  - k ones from LSB (k = 0..N) -> index k.
  - Ones in the upper bits with j zeros at the LSB end (j = 1..N-1) -> index N+j.
  - Equivalent test: at most one i with count[i] != count[i+1].
- Ring legal states: exactly one bit set; index = position of that bit (0..N-1).
- index, tc and illegal are combinational from count, mode and dir; no added latency.
- index = 0 whenever illegal = 1.
- tc is high only when the state is legal:
  - Johnson up: index 2N-1. Johnson down: index 0.
  - Ring up: index N-1. Ring down: index 0.
- Mode or dir change takes effect on the next edge. No pipeline or flush.
- If the current count is illegal in the new mode, illegal asserts immediately and the next en corrects it.
- dir change mid-sequence reverses from the current state with no skipped or repeated state. Example, N=4 Johnson: 0011 up -> 0111, then dir=1 -> 0011.
- en=0 with no clr/load: count holds; outputs remain stable.
- Reset asserted mid-operation overrides everything asynchronously. On release, the first active edge obeys the normal priority.

Test Plan:
1. N=4, arst_n low then high, mode=0, dir=0, en=1 for 9 cycles -> count 0000,0001,0011,0111,1111,1110,1100,1000,0000; index 0..7,0; tc high only at 1000.
2. N=4 Johnson, load 0111, then dir=1, en=1 for 4 cycles -> 0011,0001,0000,1000; tc high at 0000; illegal never asserted.
3. N=4, mode=1 after reset -> illegal=1 at 0000. First en -> 0001. Then en with dir=0 -> 0010,0100,1000,0001; tc at 1000.
4. N=4 Johnson, load 0101 -> illegal=1, index=0. Next en -> 0000, illegal=0. Repeat in ring mode with load 0110 -> next en gives 0001.
5. Priority: clr=load=en=1, load_val=1111, mode=1 -> 0001. Then load=en=1, load_val=0100 -> 0100. Then en=0 for 3 cycles -> holds 0100.
6. Mid-count at 0111, pulse arst_n low between edges -> count 0000 immediately, before the next edge. After release, en resumes from 0000. Repeat scenario 1 with N=3 (6 states) and N=8 (16 states).
